kd_tree_scheduler: RTL and testbench

- Sequences the kd-tree node array from its root: reads points from an external point memory and issues one command per point to the root node's top port.
- Waits for the root's response before issuing the next command.
- Two jobs: BUILD inserts N points into the tree; QUERY sends N points and returns each nearest-center result.
- Replaces the testbench-driven command/data stimulus on the root node in the container.

---
 rtl/kd_tree_scheduler_if.sv | 58 +++++
 rtl/kd_tree_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_kd_tree_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kd_tree_scheduler_if.sv
// -----------------------------------------------------------------------------
// kd_tree_scheduler_if
//
// Purpose: bundles the scheduler's two external links into one interface:
//   * the point-memory read port (address, read strobe, read data), and
//   * the command/data link to the root node's top port.
//
// Signals:
//   pt_addr        CNT_W         point memory address           (scheduler -> memory)
//   pt_rd_en       1             point memory read strobe       (scheduler -> memory)
//   pt_rd_data     DIM*DIM_SIZE  point data, 1 cycle after strobe (memory -> scheduler)
//   cmd_to_root    CMD_W         command to root top port       (scheduler -> root)
//   data_to_root   DATA_W        data to root top port          (scheduler -> root)
//   cmd_from_root  CMD_W         root response command          (root -> scheduler)
//   data_from_root DATA_W        root response data             (root -> scheduler)
//
// Modports:
//   master : the scheduler side
//   slave  : the memory/root side
// -----------------------------------------------------------------------------
interface kd_tree_scheduler_if #(
  parameter int unsigned DIM      = 3,
  parameter int unsigned DIM_SIZE = 8,
  parameter int unsigned CMD_W    = 6,
  parameter int unsigned DATA_W   = 48,
  parameter int unsigned CNT_W    = 12
);

  logic [CNT_W-1:0]        pt_addr;
  logic                    pt_rd_en;
  logic [DIM*DIM_SIZE-1:0] pt_rd_data;

  logic [CMD_W-1:0]        cmd_to_root;
  logic [DATA_W-1:0]       data_to_root;
  logic [CMD_W-1:0]        cmd_from_root;
  logic [DATA_W-1:0]       data_from_root;

  modport master (
    output pt_addr,
    output pt_rd_en,
    input  pt_rd_data,
    output cmd_to_root,
    output data_to_root,
    input  cmd_from_root,
    input  data_from_root
  );

  modport slave (
    input  pt_addr,
    input  pt_rd_en,
    output pt_rd_data,
    input  cmd_to_root,
    input  data_to_root,
    output cmd_from_root,
    output data_from_root
  );

endinterface

// File: rtl/kd_tree_scheduler.sv
// -----------------------------------------------------------------------------
// kd_tree_scheduler
//
// Purpose: drives the kd-tree node array from its root. For every point of a
// job it reads the point from an external memory, issues one command to the
// root node's top port and waits for the root's answer before moving on.
//   BUILD (mode=0): one INSERT per point, each completed by an ACK.
//   QUERY (mode=1): one QUERY per point, each completed by a RESULT whose
//                   center is reported on res_center with a res_valid pulse.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           1-cycle pulse, accepted only while idle
//   mode            0=BUILD, 1=QUERY, sampled with start
//   num_points      points in the job, sampled with start
//   bus (master)    point-memory read port and root command/response link
//   busy            high whenever a job is in progress (not idle)
//   done            1-cycle pulse at job end
//   error           sticky watchdog flag, cleared by the next accepted start
//   res_valid       1-cycle pulse per QUERY result
//   res_index       point index of the result
//   res_center      center returned by the root (upper half of its data)
//
// Per point the sequence is READ -> FETCH -> ISSUE -> WAIT, so a point costs
// at least 4 cycles; the command goes out exactly one cycle after FETCH.
//
// Optional feature, macro KD_TREE_SCHED_TIMEOUT_EN: a watchdog bounds each
// WAIT to TIMEOUT cycles; on expiry error is set, the remaining points are
// skipped and the job still ends with a done pulse. Without the macro the
// scheduler waits for the root indefinitely and error is never raised.
// -----------------------------------------------------------------------------
module kd_tree_scheduler #(
  parameter int unsigned DIM      = 3,
  parameter int unsigned DIM_SIZE = 8,
  parameter int unsigned CMD_W    = 6,
  parameter int unsigned DATA_W   = 48,
  parameter int unsigned CNT_W    = 12
`ifdef KD_TREE_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT  = 1023
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    mode,
  input  logic [CNT_W-1:0]        num_points,
  kd_tree_scheduler_if.master     bus,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    res_valid,
  output logic [CNT_W-1:0]        res_index,
  output logic [DIM*DIM_SIZE-1:0] res_center
);

  localparam int unsigned PT_W = DIM * DIM_SIZE;

  localparam logic [CMD_W-1:0] CMD_NOP    = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_INSERT = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_QUERY  = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_ACK    = CMD_W'(3);
  localparam logic [CMD_W-1:0] CMD_RESULT = CMD_W'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } state_e;

  typedef enum logic {
    JOB_BUILD = 1'b0,
    JOB_QUERY = 1'b1
  } job_e;

  state_e            state_q, state_d;
  job_e              job_q, job_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [PT_W-1:0]   point_q, point_d;
  logic              error_q, error_d;
  logic              res_valid_q, res_valid_d;
  logic [CNT_W-1:0]  res_index_q, res_index_d;
  logic [PT_W-1:0]   res_center_q, res_center_d;

`ifdef KD_TREE_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0]   wdog_q, wdog_d;
`endif

  // One extra bit so that idx+1 never wraps before it is compared with the
  // job length, even for the largest num_points.
  logic [CNT_W:0]    idx_inc;
  logic              resp_done;

  // Only the center half of the root's reply is consumed.
  logic              unused_resp_low;
  assign unused_resp_low = ^bus.data_from_root[DATA_W-PT_W-1:0];

  assign idx_inc   = {1'b0, idx_q} + (CNT_W+1)'(1);
  assign resp_done = (job_q == JOB_BUILD) ? (bus.cmd_from_root == CMD_ACK)
                                          : (bus.cmd_from_root == CMD_RESULT);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    job_d        = job_q;
    num_d        = num_q;
    idx_d        = idx_q;
    point_d      = point_q;
    error_d      = error_q;
    res_valid_d  = 1'b0;
    res_index_d  = res_index_q;
    res_center_d = res_center_q;
`ifdef KD_TREE_SCHED_TIMEOUT_EN
    wdog_d       = wdog_q;
`endif

    busy              = (state_q != S_IDLE);
    done              = (state_q == S_FINISH);
    bus.pt_rd_en      = 1'b0;
    bus.pt_addr       = '0;
    bus.cmd_to_root   = CMD_NOP;
    bus.data_to_root  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          job_d   = mode ? JOB_QUERY : JOB_BUILD;
          num_d   = num_points;
          idx_d   = '0;
          error_d = 1'b0;
          state_d = (num_points == '0) ? S_FINISH : S_READ;
        end
      end

      S_READ: begin
        bus.pt_rd_en = 1'b1;
        bus.pt_addr  = idx_q;
        state_d      = S_FETCH;
      end

      S_FETCH: begin
        // The memory answers exactly one cycle after the strobe.
        point_d = bus.pt_rd_data;
        state_d = S_ISSUE;
      end

      S_ISSUE: begin
        bus.cmd_to_root  = (job_q == JOB_BUILD) ? CMD_INSERT : CMD_QUERY;
        bus.data_to_root = {point_q, PT_W'(idx_q)};
`ifdef KD_TREE_SCHED_TIMEOUT_EN
        wdog_d           = '0;
`endif
        state_d          = S_WAIT;
      end

      S_WAIT: begin
        if (resp_done) begin
          if (job_q == JOB_QUERY) begin
            res_valid_d  = 1'b1;
            res_index_d  = idx_q;
            res_center_d = bus.data_from_root[DATA_W-1 -: PT_W];
          end
          idx_d   = idx_inc[CNT_W-1:0];
          state_d = (idx_inc < {1'b0, num_q}) ? S_READ : S_FINISH;
        end
`ifdef KD_TREE_SCHED_TIMEOUT_EN
        // A reply in the last allowed cycle still wins over the watchdog.
        else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
`endif
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign error      = error_q;
  assign res_valid  = res_valid_q;
  assign res_index  = res_index_q;
  assign res_center = res_center_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments only; all decisions
  // are made in the combinational process above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      job_q        <= JOB_BUILD;
      num_q        <= '0;
      idx_q        <= '0;
      point_q      <= '0;
      error_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_index_q  <= '0;
      res_center_q <= '0;
`ifdef KD_TREE_SCHED_TIMEOUT_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      job_q        <= job_d;
      num_q        <= num_d;
      idx_q        <= idx_d;
      point_q      <= point_d;
      error_q      <= error_d;
      res_valid_q  <= res_valid_d;
      res_index_q  <= res_index_d;
      res_center_q <= res_center_d;
`ifdef KD_TREE_SCHED_TIMEOUT_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

endmodule

// File: tb/tb_kd_tree_scheduler.sv
// -----------------------------------------------------------------------------
// tb_kd_tree_scheduler
//
// Self-checking bench for kd_tree_scheduler. A point memory and a root-node
// responder surround the design; the expected command stream, results and
// job latency are derived from the job parameters alone:
//   command i   = INSERT/QUERY with data {mem[i], i}
//   result i    = (i, center handed out by the i-th root reply)
//   job latency = num_points * (3 + reply delay) cycles from the start edge
//                 to the done pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_kd_tree_scheduler;

  localparam int unsigned DIM      = 3;
  localparam int unsigned DIM_SIZE = 8;
  localparam int unsigned CMD_W    = 6;
  localparam int unsigned DATA_W   = 48;
  localparam int unsigned CNT_W    = 12;
  localparam int unsigned PT_W     = DIM * DIM_SIZE;
`ifdef KD_TREE_SCHED_TIMEOUT_EN
  localparam int unsigned TIMEOUT  = 15;
`endif

  localparam logic [CMD_W-1:0] NOP    = CMD_W'(0);
  localparam logic [CMD_W-1:0] INSERT = CMD_W'(1);
  localparam logic [CMD_W-1:0] QUERY  = CMD_W'(2);
  localparam logic [CMD_W-1:0] ACK    = CMD_W'(3);
  localparam logic [CMD_W-1:0] RESULT = CMD_W'(4);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [CNT_W-1:0] num_points = '0;
  logic             busy, done, error, res_valid;
  logic [CNT_W-1:0] res_index;
  logic [PT_W-1:0]  res_center;

  kd_tree_scheduler_if #(
    .DIM(DIM), .DIM_SIZE(DIM_SIZE), .CMD_W(CMD_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) bus ();

  kd_tree_scheduler #(
    .DIM(DIM), .DIM_SIZE(DIM_SIZE), .CMD_W(CMD_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
`ifdef KD_TREE_SCHED_TIMEOUT_EN
    , .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .num_points (num_points),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .res_valid  (res_valid),
    .res_index  (res_index),
    .res_center (res_center)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Scoreboard counters and check task
  // --------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Point memory: data valid exactly one cycle after the strobe, garbage else
  // --------------------------------------------------------------------------
  logic [PT_W-1:0] mem [0:(1<<CNT_W)-1];

  always @(posedge clk)
    bus.pt_rd_data <= bus.pt_rd_en ? mem[bus.pt_addr] : PT_W'($urandom);

  int tick = 0;
  always @(posedge clk) tick = tick + 1;

  // --------------------------------------------------------------------------
  // Root responder: replies resp_delay cycles after a command; optional
  // ignored-code noise and spurious completion codes outside WAIT.
  // --------------------------------------------------------------------------
  logic [PT_W-1:0] centers [0:15];
  int  resp_delay = 1;
  bit  silent = 1'b0, noise = 1'b0, spur_en = 1'b0, cur_mode = 1'b0;
  int  pending = 0, spur = 0, resp_k = 0, resp_tick = -10;

  always @(negedge clk) begin : root_model
    logic [CMD_W-1:0] good;
    good = cur_mode ? RESULT : ACK;
    if (!rst_n) begin
      pending = 0;
      spur    = 0;
      bus.cmd_from_root  = NOP;
      bus.data_from_root = '0;
    end else begin
      bus.cmd_from_root  = NOP;
      bus.data_from_root = {16'($urandom), $urandom};
      if (noise) begin
        bus.cmd_from_root = CMD_W'($urandom);
        if (bus.cmd_from_root == good) bus.cmd_from_root = NOP;
      end
      if (spur > 0) begin
        bus.cmd_from_root = good;
        spur--;
      end
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          bus.cmd_from_root  = good;
          bus.data_from_root = {centers[resp_k % 16], PT_W'($urandom)};
          resp_k++;
          resp_tick = tick;
          spur = spur_en ? 3 : 0;
        end
      end
      if (!silent && (bus.cmd_to_root == INSERT || bus.cmd_to_root == QUERY))
        pending = resp_delay;
    end
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  logic [CMD_W-1:0]  obs_cmd  [$];
  logic [DATA_W-1:0] obs_data [$];
  logic [CNT_W-1:0]  obs_addr [$];
  logic [CNT_W-1:0]  obs_ridx [$];
  logic [PT_W-1:0]   obs_rctr [$];
  int done_cnt = 0, timing_err = 0, nop_data_err = 0, last_rd_tick = -10, busy_gap = 0;

  always @(negedge clk) begin
    if (bus.pt_rd_en) begin
      obs_addr.push_back(bus.pt_addr);
      last_rd_tick = tick;
    end
    if (bus.cmd_to_root != NOP) begin
      obs_cmd.push_back(bus.cmd_to_root);
      obs_data.push_back(bus.data_to_root);
      if (tick != last_rd_tick + 2) timing_err++;
    end else if (bus.data_to_root != '0) begin
      nop_data_err++;
    end
    if (res_valid) begin
      obs_ridx.push_back(res_index);
      obs_rctr.push_back(res_center);
      if (tick != resp_tick + 1) timing_err++;
    end
    if (done) done_cnt++;
  end

  // --------------------------------------------------------------------------
  // Job driver: returns the latency (cycles from the start edge to done)
  // --------------------------------------------------------------------------
  task automatic run_job(input bit m, input int n, input int d, input bit nz,
                         input bit sp, input bit dup, input int abort_at,
                         input int budget, output int lat, output bit ok,
                         output bit err_seen);
    obs_cmd.delete(); obs_data.delete(); obs_addr.delete();
    obs_ridx.delete(); obs_rctr.delete();
    done_cnt = 0; timing_err = 0; nop_data_err = 0; busy_gap = 0;
    last_rd_tick = -10;
    cur_mode = m; resp_delay = d; noise = nz; spur_en = sp; resp_k = 0;
    @(negedge clk);
    start = 1'b1; mode = m; num_points = CNT_W'(n);
    @(negedge clk);
    start = 1'b0; mode = ~m; num_points = CNT_W'($urandom);
    lat = 0; ok = 1'b0; err_seen = 1'b0;
    while (lat < budget) begin
      if (done) begin
        ok = 1'b1;
        err_seen = error;
        break;
      end
      if (!busy) busy_gap++;
      if (dup && lat == 3) begin
        start = 1'b1; mode = ~m; num_points = CNT_W'($urandom);
      end
      if (lat == 4) start = 1'b0;
      if (lat == abort_at) begin
        #2 rst_n = 1'b0;
        break;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic check_traffic(input string tag, input bit m, input int n_cmd, input int n_res);
    check({tag, ".ncmd"},  obs_cmd.size(),  n_cmd);
    check({tag, ".naddr"}, obs_addr.size(), n_cmd);
    check({tag, ".nres"},  obs_ridx.size(), n_res);
    for (int i = 0; i < obs_cmd.size() && i < n_cmd; i++) begin
      check($sformatf("%s.cmd[%0d]", tag, i), obs_cmd[i], m ? QUERY : INSERT);
      check($sformatf("%s.data[%0d]", tag, i), obs_data[i], {mem[i], PT_W'(i)});
    end
    for (int i = 0; i < obs_addr.size() && i < n_cmd; i++)
      check($sformatf("%s.addr[%0d]", tag, i), obs_addr[i], i);
    for (int i = 0; i < obs_ridx.size() && i < n_res; i++) begin
      check($sformatf("%s.ridx[%0d]", tag, i), obs_ridx[i], i);
      check($sformatf("%s.rctr[%0d]", tag, i), obs_rctr[i], centers[i % 16]);
    end
    check({tag, ".timing"},  timing_err,   0);
    check({tag, ".nopdata"}, nop_data_err, 0);
  endtask

  task automatic job_and_check(input string tag, input bit m, input int n, input int d,
                               input bit nz, input bit sp, input bit dup);
    int lat;
    bit ok, es;
    run_job(m, n, d, nz, sp, dup, -1, n * (3 + d) + 20, lat, ok, es);
    check({tag, ".done_seen"}, ok, 1);
    check({tag, ".latency"},   lat, n * (3 + d));
    check({tag, ".busy_gap"},  busy_gap, 0);
    check({tag, ".error"},     es, 0);
    @(negedge clk); #1;
    check({tag, ".idle"},      {busy, done}, 2'b00);
    check({tag, ".done_cnt"},  done_cnt, 1);
    check_traffic(tag, m, n, m ? n : 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".busy"},  busy, 0);
    check({tag, ".done"},  done, 0);
    check({tag, ".error"}, error, 0);
    check({tag, ".rv"},    res_valid, 0);
    check({tag, ".ridx"},  res_index, 0);
    check({tag, ".rctr"},  res_center, 0);
    check({tag, ".rden"},  bus.pt_rd_en, 0);
    check({tag, ".addr"},  bus.pt_addr, 0);
    check({tag, ".cmd"},   bus.cmd_to_root, 0);
    check({tag, ".data"},  bus.data_to_root, 0);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int lat;
    bit ok, es;
    for (int i = 0; i < (1 << CNT_W); i++) mem[i] = PT_W'($urandom);
    for (int i = 0; i < 16; i++) centers[i] = PT_W'($urandom);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // BUILD of 3 points, ACK two cycles after each INSERT
    job_and_check("build3", 1'b0, 3, 2, 1'b0, 1'b0, 1'b0);

    // QUERY of 2 known points with known centers, immediate reply
    mem[0] = 24'h102030; mem[1] = 24'h405060;
    centers[0] = 24'h112233; centers[1] = 24'h445566;
    job_and_check("query2", 1'b1, 2, 1, 1'b0, 1'b0, 1'b0);

    // Empty job
    job_and_check("empty", 1'b0, 0, 1, 1'b0, 1'b0, 1'b0);

    // Randomized jobs with ignored codes, spurious completions outside WAIT
    // and a second start pulse while waiting
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) centers[i] = PT_W'($urandom);
      job_and_check($sformatf("rand%0d", r), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 8)), int'($urandom_range(1, 4)),
                    1'b1, 1'b1, 1'(r % 2 == 0));
    end

    // Largest job: the index compare must not wrap
    job_and_check("max", 1'b0, (1 << CNT_W) - 1, 1, 1'b0, 1'b0, 1'b0);

    // Reset during WAIT of point 1
    run_job(1'b0, 3, 5, 1'b0, 1'b0, 1'b0, 12, 100, lat, ok, es);
    check("abort.reached", lat, 12);
    #1;
    check_outputs_zero("abort");
    repeat (3) @(negedge clk);
    #1;
    check("abort.no_done", done_cnt, 0);
    check_traffic("abort", 1'b0, 2, 0);
    rst_n = 1'b1;
    job_and_check("after_abort", 1'b0, 2, 1, 1'b0, 1'b0, 1'b0);

    // Silent root
    silent = 1'b1;
`ifdef KD_TREE_SCHED_TIMEOUT_EN
    run_job(1'b0, 3, 1, 1'b0, 1'b0, 1'b0, -1, 200, lat, ok, es);
    check("timeout.done_seen", ok, 1);
    check("timeout.latency", lat, 3 + TIMEOUT);
    check("timeout.error", es, 1);
    @(negedge clk); #1;
    check("timeout.sticky", error, 1);
    check_traffic("timeout", 1'b0, 1, 0);
    silent = 1'b0;
    job_and_check("after_timeout", 1'b1, 2, 1, 1'b0, 1'b0, 1'b0);
`else
    run_job(1'b0, 3, 1, 1'b0, 1'b0, 1'b0, -1, 1000, lat, ok, es);
    check("silent.no_done", ok, 0);
    check("silent.cycles", lat, 1000);
    check("silent.busy_gap", busy_gap, 0);
    check("silent.error", error, 0);
    check_traffic("silent", 1'b0, 1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    silent = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    job_and_check("after_silent", 1'b1, 2, 1, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog expired");
  end

endmodule
